// File: rtl/z88_kbd_pkg.sv
// rtl/z88_kbd_pkg.sv - PS/2 byte constants, receiver states and Z88 keymap lookup
package z88_kbd_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_AA = 8'hAA;
  localparam logic [7:0] PS2_FA = 8'hFA;
  localparam logic [7:0] PS2_FE = 8'hFE;
  localparam logic [7:0] PS2_EE = 8'hEE;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Returns {hit, idx} with idx = row*8+col; key is {ext, scancode}.
  function automatic logic [6:0] keymap_lookup(input logic [8:0] key);
    logic [6:0] r;
    r = 7'd0;
    case (key)
      9'h01C: r = {1'b1, 6'd45};  // A
      9'h05A: r = {1'b1, 6'd6};   // Enter
      9'h029: r = {1'b1, 6'd46};  // Space
      9'h066: r = {1'b1, 6'd7};   // Backspace / Del
      9'h012: r = {1'b1, 6'd62};  // L-Shift
      9'h059: r = {1'b1, 6'd63};  // R-Shift
      9'h175: r = {1'b1, 6'd54};  // Up
      9'h172: r = {1'b1, 6'd53};  // Down
      9'h16B: r = {1'b1, 6'd38};  // Left
      9'h174: r = {1'b1, 6'd30};  // Right
      9'h015: r = {1'b1, 6'd44};  // Q
      9'h01A: r = {1'b1, 6'd42};  // Z
      9'h04B: r = {1'b1, 6'd41};  // L
      9'h045: r = {1'b1, 6'd40};  // 0
      9'h076: r = {1'b1, 6'd61};  // Esc
      default: r = 7'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 input conditioning, frame receiver and mid-frame timeout
module ps2_rx
  import z88_kbd_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 2000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_code,
  output logic       o_code_vld,
  output logic       o_frame_err
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_clk_f;
  logic [FW-1:0] r_filt_cnt;
  logic [TW-1:0] r_to_cnt;
  rx_state_t     r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [7:0]    r_code;
  logic          r_code_vld;
  logic          r_frame_err;

  rx_state_t     w_state_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_par_nxt;
  logic          w_vld_nxt;
  logic          w_err_nxt;
  logic          w_strobe;
  logic          w_dat;

  // Strobe fires in the cycle the filtered clock commits its falling transition.
  assign w_strobe = r_clk_f && !r_clk_s[1] && (r_filt_cnt == FILT_MAX);
  assign w_dat    = r_dat_s[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_clk_f    <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], i_ps2_clk};
      r_dat_s <= {r_dat_s[0], i_ps2_dat};
      if (r_clk_s[1] == r_clk_f) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_MAX) begin
        r_clk_f    <= r_clk_s[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= RX_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_code      <= '0;
      r_code_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_par       <= w_par_nxt;
      r_code_vld  <= w_vld_nxt;
      r_frame_err <= w_err_nxt;
      if (w_vld_nxt) r_code <= r_shift;
      if (w_strobe || r_state == RX_IDLE) r_to_cnt <= '0;
      else r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_vld_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_strobe) begin
      case (r_state)
        RX_IDLE: begin
          if (!w_dat) begin
            w_state_nxt = RX_DATA;
            w_bit_nxt   = '0;
          end
        end
        RX_DATA: begin
          w_shift_nxt = {w_dat, r_shift[7:1]};
          w_bit_nxt   = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = RX_PARITY;
        end
        RX_PARITY: begin
          w_par_nxt   = w_dat;
          w_state_nxt = RX_STOP;
        end
        RX_STOP: begin
          if (w_dat && (^{r_shift, r_par})) w_vld_nxt = 1'b1;
          else w_err_nxt = 1'b1;
          w_state_nxt = RX_IDLE;
        end
        default: w_state_nxt = RX_IDLE;
      endcase
    end else if (r_state != RX_IDLE && r_to_cnt == TO_MAX) begin
      w_err_nxt   = 1'b1;
      w_state_nxt = RX_IDLE;
    end
  end

  assign o_code      = r_code;
  assign o_code_vld  = r_code_vld;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/ps2_kbmat.sv
// rtl/ps2_kbmat.sv - PS/2 scancode decoder driving the Z88 64-bit key matrix
module ps2_kbmat
  import z88_kbd_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 2000
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [63:0] kbmat,
  output logic        code_vld,
  output logic [7:0]  code,
  output logic        frame_err
);

  logic [7:0]  w_code;
  logic        w_code_vld;
  logic        w_hit;
  logic [5:0]  w_idx;
  logic [63:0] r_kbmat;
  logic        r_ext;
  logic        r_brk;
  logic [2:0]  r_skip;

  ps2_rx #(
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_rx (
    .i_clk       (mck),
    .i_rst       (rin),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_dat   (ps2_dat),
    .o_code      (w_code),
    .o_code_vld  (w_code_vld),
    .o_frame_err (frame_err)
  );

  assign {w_hit, w_idx} = keymap_lookup({r_ext, w_code});

  always_ff @(posedge mck or posedge rin) begin
    if (rin) begin
      r_kbmat <= '0;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_skip  <= '0;
    end else if (w_code_vld) begin
      // Pause emits E1 followed by seven bytes that must not touch the matrix.
      if (r_skip != 3'd0) begin
        r_skip <= r_skip - 1'b1;
      end else begin
        case (w_code)
          PS2_E0: r_ext <= 1'b1;
          PS2_F0: r_brk <= 1'b1;
          PS2_E1: begin
            r_skip <= PAUSE_SKIP;
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
          end
          PS2_AA, PS2_FA, PS2_FE, PS2_EE: ;
          8'h00, 8'hFF: begin
            r_kbmat <= '0;
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
          end
          default: begin
            if (w_hit) r_kbmat[w_idx] <= !r_brk;
            r_ext <= 1'b0;
            r_brk <= 1'b0;
          end
        endcase
      end
    end
  end

  assign kbmat    = r_kbmat;
  assign code     = w_code;
  assign code_vld = w_code_vld;

endmodule

// File: doc/ps2_kbmat.md
Name: ps2_kbmat

Overview:
- Drives the 64-bit keyboard matrix `kbmat` that the gate array samples on every keyboard-port read.
- Receives PS/2 keyboard frames and decodes scancodes, including E0 and F0 prefixes.
- Maintains one "pressed" bit per Z88 matrix position.
- Bit index is row*8+col; row r is the column read when address line `ca[8+r]` is low. A bit value of 1 means the key is down.

Parameters:
- FILT_LEN, 8: consecutive identical `mck` samples needed to accept a new PS/2 clock level.
- TIMEOUT, 2000: `mck` cycles without a PS/2 clock falling edge mid-frame before the frame is abandoned (about 200 us at 9.83 MHz).

Ports:
- mck  in  1  master clock, 9.83 MHz.
- rin  in  1  reset, asynchronous, active-high.
- ps2_clk  in  1  PS/2 clock, asynchronous to `mck`.
- ps2_dat  in  1  PS/2 data, asynchronous to `mck`.
- kbmat  out  64  key-pressed matrix, 1 = pressed.
- code_vld  out  1  one-cycle pulse when a byte is accepted with good parity and stop bit.
- code  out  8  last accepted byte; valid while `code_vld` is high, held otherwise.
- frame_err  out  1  one-cycle pulse on a parity error, missing stop bit, or timeout.

Behaviour:
- Reset: `kbmat`=0, `code`=00, `code_vld`=0, `frame_err`=0. All FSMs go to IDLE; prefix flags and skip counter cleared. Reset mid-frame discards the partial frame.
- Input conditioning:
  - `ps2_clk` and `ps2_dat` each pass through a 2-FF synchroniser.
  - The clock is then glitch-filtered: the filtered level changes only after FILT_LEN equal samples.
  - A falling edge of the filtered clock is a bit strobe; data is sampled on the synchronised `ps2_dat` in that cycle.
- Receiver FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: a strobe with dat=0 goes to DATA; a strobe with dat=1 is ignored.
  - DATA: 8 strobes shift bits in LSB first, then go to PARITY.
  - PARITY: one strobe; the parity bit is captured. Odd parity over the 8 data bits plus the parity bit is required.
  - STOP: one strobe; dat must be 1.
  - On success, `code_vld`=1 and `code`=byte on the cycle after the stop strobe.
  - On a bad parity or stop bit, `frame_err` pulses in that same cycle and the FSM returns to IDLE.
  - Timeout counter: reset on every strobe, counts while the FSM is not IDLE. On reaching TIMEOUT it pulses `frame_err` and returns to IDLE. A half frame never produces `code_vld`.
- Decoder, acting on `code_vld` only:
  - E0: set ext flag. F0: set brk flag. Flags persist until the next non-prefix byte, then both clear.
  - E1: enter skip mode; the next 7 bytes are dropped without updating the matrix (Pause sequence).
  - AA, FA, FE, EE: ignored; flags unchanged.
  - 00 or FF (keyboard overrun): `kbmat` cleared to 0, flags cleared.
  - Any other byte: look up {ext, byte} in KEYMAP.
    - Hit: bit[idx] is set to !brk.
    - Miss: no change.
  - The `kbmat` update occurs one cycle after `code_vld`.
  - A make for an already-set bit or a break for a clear bit is harmless (idempotent).
- Simultaneous events: reset dominates. A strobe that coincides with a timeout is treated as a strobe; the counter wins reset.
- Multiple keys: any number of bits may be 1 at once; no ghosting logic.

Decomposition:
- Package `z88_kbd_pkg`:
  - PS/2 byte constants: E0, F0, E1, AA, FA, FE, EE.
  - KEYMAP lookup function: 9-bit {ext, code} in, {hit, 6-bit idx} out.
  - Required KEYMAP entries:
    - 1C (A) -> 45
    - 5A (Enter) -> 6
    - 29 (Space) -> 46
    - 66 (Backspace) -> 7
    - 12 (L-Shift) -> 62
    - 59 (R-Shift) -> 63
    - E0 75 (Up) -> 54
    - E0 72 (Down) -> 53
  - The remaining entries follow the Z88 matrix chart.
- Sub-module `ps2_rx`: synchroniser, filter, receiver FSM and timeout. Outputs `code`/`code_vld`/`frame_err`. `ps2_kbmat` adds the decoder and matrix register.

Test Plan:
- Make then break: frames 1C, then F0 1C -> after 1C, `kbmat`[45]=1 and all other bits 0; after F0 1C, `kbmat`=0. `code_vld` pulses 3 times.
- Extended key plus chord: frames 12, then E0 75 -> bits 62 and 54 set. Then E0 F0 75 -> bit 54 clears and bit 62 stays 1.
- Parity error: frame 1C sent with even parity -> `frame_err` pulses once, no `code_vld`, `kbmat` unchanged; a following good 5A sets bit 6.
- Timeout: start bit plus 4 data bits, then the clock stops for TIMEOUT+10 cycles -> one `frame_err` pulse and return to IDLE; a subsequent full 29 frame sets bit 46.
- Glitch and Pause: a 3-cycle low glitch on `ps2_clk` is not counted. The Pause sequence E1 14 77 E1 F0 14 F0 77 leaves `kbmat` unchanged.
- Overrun and reset: with bits 45 and 6 set, frame 00 -> `kbmat`=0. Assert `rin` mid-frame -> all outputs 0 immediately; the next full frame decodes correctly.
